// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states and LM/SM opcodes.
package risc_pipe_pkg;

   typedef enum logic {
      IDLE,
      MULTI
   } state_t;

   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes out.
interface pipe_hazard_ctrl_if #(
   parameter int NREG = 8
);
   logic            mem_stall;
   logic            ex_redirect;
   logic            ex_memread;
   logic            ex_dest_wr;
   logic [2:0]      ex_dest;
   logic            rr_valid;
   logic [3:0]      rr_op;
   logic [NREG-1:0] rr_mask;
   logic            rr_use_a;
   logic            rr_use_b;
   logic [2:0]      rr_src_a;
   logic [2:0]      rr_src_b;
   logic            pc_write;
   logic            if_id_write;
   logic            id_rr_write;
   logic            rr_ex_write;
   logic            ex_mem_write;
   logic            if_flush;
   logic            id_flush;
   logic            rr_flush;
   logic            multi_active;
   logic [2:0]      multi_reg;
   logic [2:0]      multi_cnt;

   modport master (
      output mem_stall, ex_redirect, ex_memread, ex_dest_wr,
      output ex_dest, rr_valid, rr_op, rr_mask,
      output rr_use_a, rr_use_b, rr_src_a, rr_src_b,
      input  pc_write, if_id_write, id_rr_write,
      input  rr_ex_write, ex_mem_write,
      input  if_flush, id_flush, rr_flush,
      input  multi_active, multi_reg, multi_cnt
   );

   modport slave (
      input  mem_stall, ex_redirect, ex_memread, ex_dest_wr,
      input  ex_dest, rr_valid, rr_op, rr_mask,
      input  rr_use_a, rr_use_b, rr_src_a, rr_src_b,
      output pc_write, if_id_write, id_rr_write,
      output rr_ex_write, ex_mem_write,
      output if_flush, id_flush, rr_flush,
      output multi_active, multi_reg, multi_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_lowbit_enc.sv
// Lowest-set-bit encoder: index, valid flag and one-hot clear mask.
module lowbit_enc #(
   parameter  int NREG = 8,
   localparam int IW   = $clog2(NREG)
) (
   input  logic [NREG-1:0] mask,
   output logic [IW-1:0]   idx,
   output logic            valid,
   output logic [NREG-1:0] clr
);
   always_comb begin
      idx = '0;
      for (int i = NREG - 1; i >= 0; i--)
         if (mask[i]) idx = IW'(i);
   end

   assign valid = |mask;
   // two's-complement trick isolates the lowest set bit
   assign clr   = mask & (~mask + NREG'(1));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and LM/SM micro-op walk.
// Optional perf counters under PIPE_CTRL_PERF_EN.
import risc_pipe_pkg::*;

module pipe_hazard_ctrl #(
   parameter int NREG  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PIPE_CTRL_PERF_EN
   output logic [CNT_W-1:0] perf_stall_cyc,
   output logic [CNT_W-1:0] perf_flush_cnt,
`endif
   pipe_hazard_ctrl_if.slave hz
);
   state_t          state, nxt_state;
   logic [NREG-1:0] rem, nxt_rem;
   logic [2:0]      cnt, nxt_cnt;
   logic [NREG-1:0] enc_in, clr;
   logic [2:0]      idx;
   logic            valid, more, lu, lmsm;

   assign enc_in = (state == MULTI) ? rem : hz.rr_mask;

   lowbit_enc #(.NREG(NREG)) u_enc (
      .mask  (enc_in),
      .idx   (idx),
      .valid (valid),
      .clr   (clr)
   );

   assign more = |(enc_in & ~clr);
   assign lmsm = hz.rr_valid &
                 (hz.rr_op == OP_LM || hz.rr_op == OP_SM);
   assign lu   = hz.ex_memread & hz.ex_dest_wr & hz.rr_valid &
                 ((hz.rr_use_a & (hz.rr_src_a == hz.ex_dest)) |
                  (hz.rr_use_b & (hz.rr_src_b == hz.ex_dest)));

   always_comb begin
      hz.pc_write     = 1'b1;
      hz.if_id_write  = 1'b1;
      hz.id_rr_write  = 1'b1;
      hz.rr_ex_write  = 1'b1;
      hz.ex_mem_write = 1'b1;
      hz.if_flush     = 1'b0;
      hz.id_flush     = 1'b0;
      hz.rr_flush     = 1'b0;
      hz.multi_active = 1'b0;
      hz.multi_reg    = '0;
      hz.multi_cnt    = '0;
      nxt_state       = state;
      nxt_rem         = rem;
      nxt_cnt         = cnt;
      if (hz.mem_stall) begin
         hz.pc_write     = 1'b0;
         hz.if_id_write  = 1'b0;
         hz.id_rr_write  = 1'b0;
         hz.rr_ex_write  = 1'b0;
         hz.ex_mem_write = 1'b0;
         if (state == MULTI) begin
            hz.multi_active = 1'b1;
            hz.multi_reg    = idx;
            hz.multi_cnt    = cnt;
         end
      end else if (hz.ex_redirect) begin
         // the LM/SM is younger than the branch, so it dies too
         hz.if_flush = 1'b1;
         hz.id_flush = 1'b1;
         hz.rr_flush = 1'b1;
         nxt_state   = IDLE;
         nxt_rem     = '0;
         nxt_cnt     = '0;
      end else if (state == MULTI) begin
         hz.multi_active = 1'b1;
         hz.multi_reg    = idx;
         hz.multi_cnt    = cnt;
         if (more) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_rr_write = 1'b0;
            nxt_rem        = enc_in & ~clr;
            nxt_cnt        = cnt + 3'd1;
         end else begin
            nxt_state = IDLE;
            nxt_rem   = '0;
            nxt_cnt   = '0;
         end
      end else if (lmsm) begin
         if (!valid) begin
            hz.rr_flush = 1'b1;
         end else begin
            hz.multi_active = 1'b1;
            hz.multi_reg    = idx;
            if (more) begin
               hz.pc_write    = 1'b0;
               hz.if_id_write = 1'b0;
               hz.id_rr_write = 1'b0;
               nxt_state      = MULTI;
               nxt_rem        = enc_in & ~clr;
               nxt_cnt        = 3'd1;
            end
         end
      end else if (lu) begin
         hz.pc_write    = 1'b0;
         hz.if_id_write = 1'b0;
         hz.id_rr_write = 1'b0;
         hz.rr_flush    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         cnt   <= '0;
      end else if (!hz.mem_stall) begin
         state <= nxt_state;
         rem   <= nxt_rem;
         cnt   <= nxt_cnt;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!hz.pc_write && !(&perf_stall_cyc))
            perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
         if (hz.ex_redirect && !hz.mem_stall &&
             !(&perf_flush_cnt))
            perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (perf checks with PIPE_CTRL_PERF_EN).
module tb_pipe_hazard_ctrl;
   import risc_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.NREG(8)) hz ();

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] perf_stall_cyc, perf_flush_cnt;
`endif

   pipe_hazard_ctrl #(.NREG(8), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef PIPE_CTRL_PERF_EN
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .hz             (hz)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      hz.mem_stall   = 0;
      hz.ex_redirect = 0;
      hz.ex_memread  = 0;
      hz.ex_dest_wr  = 0;
      hz.ex_dest     = 0;
      hz.rr_valid    = 0;
      hz.rr_op       = 0;
      hz.rr_mask     = 0;
      hz.rr_use_a    = 0;
      hz.rr_use_b    = 0;
      hz.rr_src_a    = 0;
      hz.rr_src_b    = 0;
   endtask

   task automatic load_use_a();
      hz.ex_memread = 1;
      hz.ex_dest_wr = 1;
      hz.ex_dest    = 3;
      hz.rr_valid   = 1;
      hz.rr_op      = 4'b0000;
      hz.rr_use_a   = 1;
      hz.rr_src_a   = 3;
   endtask

   initial begin
      rst = 1;
      clr_in();
      tick();
      tick();
      rst = 0;
      #1;
      chk("rst_pc_write", hz.pc_write, 1);
      chk("rst_ex_mem_write", hz.ex_mem_write, 1);
      chk("rst_rr_flush", hz.rr_flush, 0);
      chk("rst_multi_active", hz.multi_active, 0);

      // load-use on source A
      load_use_a();
      #1;
      chk("lu_pc_write", hz.pc_write, 0);
      chk("lu_if_id_write", hz.if_id_write, 0);
      chk("lu_rr_ex_write", hz.rr_ex_write, 1);
      chk("lu_rr_flush", hz.rr_flush, 1);
      tick();
      hz.ex_memread = 0;
      #1;
      chk("lu_after_pc_write", hz.pc_write, 1);
      chk("lu_after_rr_flush", hz.rr_flush, 0);
      // matching register but unused port: no hazard
      hz.ex_memread = 1;
      hz.rr_use_a   = 0;
      #1;
      chk("lu_unused_pc_write", hz.pc_write, 1);
      // hazard via source B
      hz.rr_use_b = 1;
      hz.rr_src_b = 3;
      #1;
      chk("lu_b_pc_write", hz.pc_write, 0);
      tick();
      clr_in();

      // LM mask 1010_0100
      hz.rr_valid = 1;
      hz.rr_op    = OP_LM;
      hz.rr_mask  = 8'b1010_0100;
      #1;
      chk("lm_c0_active", hz.multi_active, 1);
      chk("lm_c0_reg", hz.multi_reg, 2);
      chk("lm_c0_cnt", hz.multi_cnt, 0);
      chk("lm_c0_pc_write", hz.pc_write, 0);
      chk("lm_c0_rr_ex_write", hz.rr_ex_write, 1);
      tick();
      chk("lm_c1_reg", hz.multi_reg, 5);
      chk("lm_c1_cnt", hz.multi_cnt, 1);
      chk("lm_c1_pc_write", hz.pc_write, 0);
      tick();
      chk("lm_c2_reg", hz.multi_reg, 7);
      chk("lm_c2_cnt", hz.multi_cnt, 2);
      chk("lm_c2_pc_write", hz.pc_write, 1);
      chk("lm_c2_id_rr_write", hz.id_rr_write, 1);
      tick();
      clr_in();
      #1;
      chk("lm_done_active", hz.multi_active, 0);

      // LM 0xFF, redirect on the third micro-op
      hz.rr_valid = 1;
      hz.rr_op    = OP_LM;
      hz.rr_mask  = 8'hFF;
      #1;
      chk("ff_c0_reg", hz.multi_reg, 0);
      tick();
      chk("ff_c1_reg", hz.multi_reg, 1);
      tick();
      chk("ff_c2_reg", hz.multi_reg, 2);
      hz.ex_redirect = 1;
      #1;
      chk("ff_redir_if_flush", hz.if_flush, 1);
      chk("ff_redir_id_flush", hz.id_flush, 1);
      chk("ff_redir_rr_flush", hz.rr_flush, 1);
      chk("ff_redir_pc_write", hz.pc_write, 1);
      tick();
      clr_in();
      #1;
      chk("ff_after_active", hz.multi_active, 0);
      chk("ff_after_pc_write", hz.pc_write, 1);

      // SM R0,R1,R3 with a 4-cycle memory stall mid-sequence
      hz.rr_valid = 1;
      hz.rr_op    = OP_SM;
      hz.rr_mask  = 8'b0000_1011;
      #1;
      chk("sm_c0_reg", hz.multi_reg, 0);
      tick();
      hz.mem_stall = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("sm_stall_reg", hz.multi_reg, 1);
         chk("sm_stall_cnt", hz.multi_cnt, 1);
         chk("sm_stall_pc_write", hz.pc_write, 0);
         chk("sm_stall_rr_ex_write", hz.rr_ex_write, 0);
         chk("sm_stall_ex_mem_write", hz.ex_mem_write, 0);
         tick();
      end
      hz.mem_stall = 0;
      #1;
      chk("sm_c1_reg", hz.multi_reg, 1);
      chk("sm_c1_cnt", hz.multi_cnt, 1);
      chk("sm_c1_pc_write", hz.pc_write, 0);
      tick();
      chk("sm_c2_reg", hz.multi_reg, 3);
      chk("sm_c2_cnt", hz.multi_cnt, 2);
      chk("sm_c2_pc_write", hz.pc_write, 1);
      tick();
      clr_in();

      // mem_stall outranks redirect
      hz.mem_stall   = 1;
      hz.ex_redirect = 1;
      #1;
      chk("ms_redir_if_flush", hz.if_flush, 0);
      chk("ms_redir_pc_write", hz.pc_write, 0);
      tick();
      clr_in();

      // SM mask 0 becomes a NOP
      hz.rr_valid = 1;
      hz.rr_op    = OP_SM;
      #1;
      chk("sm0_rr_flush", hz.rr_flush, 1);
      chk("sm0_pc_write", hz.pc_write, 1);
      chk("sm0_active", hz.multi_active, 0);
      tick();
      clr_in();
      #1;
      chk("sm0_after_rr_flush", hz.rr_flush, 0);

      // single-bit LM: one micro-op, no stall
      hz.rr_valid = 1;
      hz.rr_op    = OP_LM;
      hz.rr_mask  = 8'b0001_0000;
      #1;
      chk("lm1_active", hz.multi_active, 1);
      chk("lm1_reg", hz.multi_reg, 4);
      chk("lm1_pc_write", hz.pc_write, 1);
      tick();
      clr_in();
      #1;
      chk("lm1_after_active", hz.multi_active, 0);

      // reset mid-MULTI
      hz.rr_valid = 1;
      hz.rr_op    = OP_LM;
      hz.rr_mask  = 8'hFF;
      tick();
      chk("rmid_reg", hz.multi_reg, 1);
      rst = 1;
      tick();
      rst = 0;
      clr_in();
      #1;
      chk("rmid_active", hz.multi_active, 0);
      chk("rmid_pc_write", hz.pc_write, 1);

`ifdef PIPE_CTRL_PERF_EN
      chk("perf_rst_stall", perf_stall_cyc, 0);
      chk("perf_rst_flush", perf_flush_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         load_use_a();
         tick();
         clr_in();
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         hz.ex_redirect = 1;
         tick();
         clr_in();
         tick();
      end
      chk("perf_stall_cyc", perf_stall_cyc, 3);
      chk("perf_flush_cnt", perf_flush_cnt, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
